// File: rtl/alu_pkg.sv
// Shared opcode and FSM definitions for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// hi/lo present the accumulator value *after* the step in progress, so the
// parent can capture the final answer on the same edge that fin is high.
module alu_muldiv #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             fin,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] rem_q, rem_d;   // upper half: product high / partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;     // lower half: multiplier / dividend -> quotient
  logic [WIDTH-1:0] opb_q;          // multiplicand / divisor
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             div_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;

  // One iteration of the selected algorithm.
  always_comb begin
    sum     = '0;
    shifted = '0;
    rem_d   = rem_q;
    lo_d    = lo_q;
    if (div_q) begin
      shifted = {rem_q, lo_q[WIDTH-1]};
      if (shifted >= {1'b0, opb_q}) begin
        rem_d = WIDTH'(shifted - {1'b0, opb_q});
        lo_d  = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted[WIDTH-1:0];
        lo_d  = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum   = {1'b0, rem_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
      rem_d = sum[WIDTH:1];
      lo_d  = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign busy = busy_q;
  assign fin  = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign hi   = rem_d;
  assign lo   = lo_d;

  // Operand latch on start, then WIDTH iterations while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      lo_q   <= '0;
      opb_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      div_q  <= 1'b0;
    end else if (start_mul || start_div) begin
      rem_q  <= '0;
      lo_q   <= a;
      opb_q  <= b;
      cnt_q  <= '0;
      busy_q <= 1'b1;
      div_q  <= start_div;
    end else if (busy_q) begin
      rem_q <= rem_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + 1'b1;
      if (fin) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative MULU/DIVU,
// with registered results and a start/done handshake.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUctr,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Hi,
  output logic             Zero,
  output logic             Overflow
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             start_mul, start_div;
  logic             md_busy, md_fin;
  logic [WIDTH-1:0] md_hi, md_lo;

  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf;

  alu_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .start_mul(start_mul),
    .start_div(start_div),
    .a        (A),
    .b        (B),
    .busy     (md_busy),
    .fin      (md_fin),
    .hi       (md_hi),
    .lo       (md_lo)
  );

  // Single-cycle operation results.
  always_comb begin
    sum     = A + B;
    diff    = A - B;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ALUctr)
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_XOR:  alu_res = A ^ B;
      OP_NOR:  alu_res = ~(A | B);
      OP_SLTU: alu_res = WIDTH'(A < B);
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:  alu_res = WIDTH'($signed(A) < $signed(B));
      default: alu_res = '0;
    endcase
  end

  // Next-state and output-register update.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    hi_d      = hi_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    start_mul = 1'b0;
    start_div = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (ALUctr == OP_MULU) begin
            start_mul = 1'b1;
            state_d   = S_MUL;
          end else if (ALUctr == OP_DIVU) begin
            start_div = 1'b1;
            state_d   = S_DIV;
          end else begin
            result_d = alu_res;
            hi_d     = '0;
            zero_d   = (alu_res == '0);
            ovf_d    = alu_ovf;
            done_d   = 1'b1;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (md_fin) begin
          result_d = md_lo;
          hi_d     = md_hi;
          zero_d   = (md_lo == '0);
          ovf_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign busy     = md_busy;
  assign done     = done_q;
  assign Result   = result_q;
  assign Hi       = hi_q;
  assign Zero     = zero_q;
  assign Overflow = ovf_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised next-generation ALU for the datapath.
- Adds a registered start/done handshake and an iterative multiply/divide unit to the single-cycle arithmetic/logic ops.
- Width is generic (WIDTH). Results are registered and held until the next operation completes.
- Sits in the EX stage; the controller issues start and stalls on busy.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 4..64)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous active-high reset
start  input  1  issue request; sampled only when busy=0
ALUctr  input  4  operation code, sampled with start
A  input  WIDTH  operand A, sampled with start
B  input  WIDTH  operand B, sampled with start
busy  output  1  high while a multi-cycle op is iterating
done  output  1  one-cycle pulse: Result/Hi/Zero/Overflow valid and updated
Result  output  WIDTH  primary result (low product / quotient for MULU/DIVU)
Hi  output  WIDTH  high product or remainder; 0 for single-cycle ops
Zero  output  1  registered (Result == 0)
Overflow  output  1  signed overflow of ADD/SUB; 0 for all other ops

Behaviour:
- Reset: the single clock is clk; reset is synchronous and active-high. While reset=1 at a rising edge:
  - busy, done, Result, Hi, Zero and Overflow go to 0.
  - The FSM goes to IDLE.
  - Reset mid-operation aborts the operation with no done pulse.
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0100 NOR; 0101 SLTU; 0110 SUB; 0111 SLT; 1000 MULU; 1001 DIVU.
  - 1010-1111 are reserved: treated as single-cycle, Result=0, Hi=0.
- FSM states: IDLE, MUL, DIV.
  - IDLE + start + single-cycle op: outputs registered at the same edge; done=1 the next cycle (latency 1); FSM stays IDLE.
  - IDLE + start + MULU: operands latched; go to MUL.
  - IDLE + start + DIVU: operands latched; go to DIV.
  - MUL/DIV: an iteration counter runs WIDTH steps; busy=1 for WIDTH cycles.
  - On the final step: outputs written, done=1 the following cycle, return to IDLE.
  - Total latency for MULU/DIVU: start sampled at edge t, done high in cycle t+WIDTH+1.
- Back-to-back: start may be asserted in the same cycle that done is high. It is accepted, since busy=0.
- start while busy=1 is ignored; no queueing.
- ALUctr/A/B changes during busy have no effect, because operands are latched.
- ADD/SUB: modulo 2^WIDTH. Overflow=1 when the operand signs (B inverted for SUB) agree and the result sign differs.
- SLT: signed compare. SLTU: unsigned compare. Result = {0..0, lt}.
- MULU:
  - Unsigned shift-add, one partial product per cycle.
  - Outputs: {Hi, Result} = A*B (2*WIDTH bits).
- DIVU:
  - Unsigned restoring division, one quotient bit per cycle.
  - Outputs: Result = A/B, Hi = A%B.
  - B=0: Result = all ones, Hi = A; same latency, never hangs.
- Zero is computed from the final Result value and registered with it.
- Outputs hold their last values between done pulses. done is never high for two consecutive cycles unless two ops complete back-to-back.

Decomposition:
- Shared package alu_pkg holds:
  - ALUctr opcode localparams (OP_AND .. OP_DIVU).
  - FSM state encoding (S_IDLE, S_MUL, S_DIV).
- One sub-module is natural: alu_muldiv.
  - Contains the iterative multiply/divide datapath with counter.
  - Interface: start_mul/start_div, busy, fin, hi, lo.
- alu_seq contains the single-cycle ops, the FSM and the output registers.

Test Plan:
- WIDTH=8, SUB A=0x32 B=0x35 -> done at t+1, Result=0xFD, Zero=0, Overflow=0, Hi=0.
- ADD 0x7F+0x01 -> Result=0x80, Overflow=1. Then SUB 0x80-0x01 -> 0x7F, Overflow=1. Then SUB 0x35-0x35 -> Result=0x00, Zero=1.
- MULU 0xFF*0xFF -> busy high 8 cycles, done at t+9, Hi=0xFE, Result=0x01. A second start during busy is ignored (no extra done).
- DIVU 0x64/0x07 -> Result=0x0E, Hi=0x02 at t+9. DIVU 0x5A/0x00 -> Result=0xFF, Hi=0x5A, done at t+9.
- Reset asserted 3 cycles into MULU -> next cycle busy=0, Result=0, Hi=0, no done. A following SLT 0x80,0x01 -> Result=0x01; SLTU with the same operands -> Result=0x00.
- Repeat the MULU/DIVU scenarios at WIDTH=32: 0xFFFFFFFF*2 -> Hi=0x1, Result=0xFFFFFFFE, done at t+33.
